// File: rtl/ser_frame_tx.sv
// Serial frame generator: start bit, 2-bit port, 4-bit count, then N payload
// bits, all MSB first, advancing one bit per bit_en strobe.
module ser_frame_tx #(
    parameter int DATA_W = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [1:0]        port_sel,
    input  logic [3:0]        len,
    input  logic [DATA_W-1:0] data,
    input  logic              bit_en,
    output logic              ser_out,
    output logic              busy,
    output logic              done
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_START = 3'd1;
    localparam logic [2:0] S_PORT  = 3'd2;
    localparam logic [2:0] S_CNT   = 3'd3;
    localparam logic [2:0] S_DATA  = 3'd4;

    logic [2:0]        state_q, state_d;
    logic [1:0]        port_q, port_d;
    logic [3:0]        len_q, len_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [3:0]        idx_q, idx_d;
    logic              ser_q, ser_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              end_frame;

    always_comb begin
        state_d   = state_q;
        port_d    = port_q;
        len_d     = len_q;
        data_d    = data_q;
        idx_d     = idx_q;
        ser_d     = ser_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        end_frame = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    port_d  = port_sel;
                    len_d   = len;
                    data_d  = data;
                    idx_d   = 4'd0;
                    state_d = S_START;
                    ser_d   = 1'b1;
                    busy_d  = 1'b1;
                end
            end
            S_START: begin
                if (bit_en) begin
                    state_d = S_PORT;
                    idx_d   = 4'd1;
                    ser_d   = port_q[1];
                end
            end
            S_PORT: begin
                if (bit_en) begin
                    if (idx_q != 4'd0) begin
                        idx_d = 4'd0;
                        ser_d = port_q[0];
                    end else begin
                        state_d = S_CNT;
                        idx_d   = 4'd3;
                        ser_d   = len_q[3];
                    end
                end
            end
            S_CNT: begin
                if (bit_en) begin
                    if (idx_q != 4'd0) begin
                        idx_d = idx_q - 4'd1;
                        ser_d = len_q[idx_q-4'd1];
                    end else if (len_q != 4'd0) begin
                        state_d = S_DATA;
                        idx_d   = len_q - 4'd1;
                        ser_d   = data_q[len_q-4'd1];
                    end else begin
                        end_frame = 1'b1;
                    end
                end
            end
            S_DATA: begin
                // idx_q stops at 0; the strobe after data[0] closes the frame
                if (bit_en) begin
                    if (idx_q != 4'd0) begin
                        idx_d = idx_q - 4'd1;
                        ser_d = data_q[idx_q-4'd1];
                    end else begin
                        end_frame = 1'b1;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                ser_d   = 1'b0;
                busy_d  = 1'b0;
            end
        endcase

        if (end_frame) begin
            state_d = S_IDLE;
            idx_d   = 4'd0;
            ser_d   = 1'b0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            port_q  <= '0;
            len_q   <= '0;
            data_q  <= '0;
            idx_q   <= '0;
            ser_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            port_q  <= port_d;
            len_q   <= len_d;
            data_q  <= data_d;
            idx_q   <= idx_d;
            ser_q   <= ser_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign ser_out = ser_q;
    assign busy    = busy_q;
    assign done    = done_q;

endmodule

// File: tb/tb_ser_frame_tx.sv
// Bench for ser_frame_tx: fixed vector table, directed corner sequences and
// random traffic checked against a bit-list frame model.
module tb_ser_frame_tx;

    localparam int DW = 15;

    logic          clk;
    logic          rst;
    logic          start;
    logic [1:0]    port_sel;
    logic [3:0]    len;
    logic [DW-1:0] data;
    logic          bit_en;
    logic          ser_out;
    logic          busy;
    logic          done;

    int nvec;
    int nmis;
    int cyc;

    ser_frame_tx #(.DATA_W(DW)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .port_sel(port_sel),
        .len     (len),
        .data    (data),
        .bit_en  (bit_en),
        .ser_out (ser_out),
        .busy    (busy),
        .done    (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Frame model: the whole frame as a list of bits plus a position.
    bit m_bits[32];
    int m_n;
    int m_pos;
    bit m_busy;
    bit m_ser;
    bit m_done;

    task automatic model_edge(input logic r, input logic s,
                              input logic [1:0] p, input logic [3:0] l,
                              input logic [DW-1:0] d, input logic b);
        if (r) begin
            m_busy = 0;
            m_ser  = 0;
            m_done = 0;
        end else if (!m_busy) begin
            m_done = 0;
            if (s) begin
                m_bits[0] = 1'b1;
                m_bits[1] = p[1];
                m_bits[2] = p[0];
                for (int i = 0; i < 4; i++) m_bits[3+i] = l[3-i];
                for (int i = 0; i < int'(l); i++)
                    m_bits[7+i] = d[int'(l)-1-i];
                m_n    = 7 + int'(l);
                m_pos  = 0;
                m_busy = 1;
                m_ser  = 1;
            end
        end else begin
            m_done = 0;
            if (b) begin
                m_pos++;
                if (m_pos == m_n) begin
                    m_busy = 0;
                    m_ser  = 0;
                    m_done = 1;
                end else begin
                    m_ser = m_bits[m_pos];
                end
            end
        end
    endtask

    task automatic cmp(input string nm, input logic act, input logic exp);
        nvec++;
        if (act !== exp) begin
            nmis++;
            $display("FAIL %s cycle %0d: got %b expected %b", nm, cyc, act, exp);
        end
    endtask

    task automatic step(input logic r, input logic s,
                        input logic [1:0] p, input logic [3:0] l,
                        input logic [DW-1:0] d, input logic b,
                        input bit chk);
        rst      = r;
        start    = s;
        port_sel = p;
        len      = l;
        data     = d;
        bit_en   = b;
        model_edge(r, s, p, l, d, b);
        @(posedge clk);
        #1;
        cyc++;
        if (chk) begin
            cmp("ser_out", ser_out, m_ser);
            cmp("busy", busy, m_busy);
            cmp("done", done, m_done);
        end
    endtask

    // Start a frame, then step until the model sees done; returns busy count.
    task automatic run_frame(input logic [1:0] p, input logic [3:0] l,
                             input logic [DW-1:0] d, input int be_period,
                             output int busy_cycles);
        int j;
        busy_cycles = 0;
        step(0, 1, p, l, d, 1'b1, 1);
        if (busy) busy_cycles++;
        j = 1;
        while (!m_done && j < 80) begin
            step(0, 0, 2'($urandom), 4'($urandom), DW'($urandom),
                 (j % be_period) == 0, 1);
            if (busy) busy_cycles++;
            j++;
        end
        if (!m_done) begin
            nvec++;
            nmis++;
            $display("FAIL frame_timeout cycle %0d: no done after %0d cycles",
                     cyc, j);
        end
    endtask

    typedef struct {
        logic          r;
        logic          s;
        logic [1:0]    p;
        logic [3:0]    l;
        logic [DW-1:0] d;
        logic          b;
        logic          e_ser;
        logic          e_busy;
        logic          e_done;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic r, logic s, logic [1:0] p, logic [3:0] l,
                                logic [DW-1:0] d, logic b,
                                logic es, logic eb, logic ed);
        vec_t v;
        v.r = r; v.s = s; v.p = p; v.l = l; v.d = d; v.b = b;
        v.e_ser = es; v.e_busy = eb; v.e_done = ed;
        return v;
    endfunction

    initial begin
        logic [10:0] basic_bits;
        logic [6:0]  zero_bits;
        int          bc;

        nvec = 0;
        nmis = 0;
        cyc  = 0;
        m_busy = 0; m_ser = 0; m_done = 0; m_n = 0; m_pos = 0;
        rst = 1; start = 0; port_sel = 0; len = 0; data = 0; bit_en = 0;

        basic_bits = 11'b11001001011;
        zero_bits  = 7'b1010000;

        for (int i = 0; i < 5; i++)
            tbl.push_back(mk(1, 1, 2'b11, 4'hf, 15'h7fff, 1, 0, 0, 0));
        tbl.push_back(mk(0, 1, 2'b10, 4'd4, 15'b1011, 1, basic_bits[10], 1, 0));
        for (int i = 1; i < 11; i++)
            tbl.push_back(mk(0, 0, 2'b00, 4'd0, 15'h0, 1, basic_bits[10-i], 1, 0));
        tbl.push_back(mk(0, 0, 2'b00, 4'd0, 15'h0, 1, 0, 0, 1));
        tbl.push_back(mk(0, 0, 2'b00, 4'd0, 15'h0, 1, 0, 0, 0));
        tbl.push_back(mk(0, 1, 2'b01, 4'd0, 15'h7fff, 1, zero_bits[6], 1, 0));
        for (int i = 1; i < 7; i++)
            tbl.push_back(mk(0, 0, 2'b11, 4'hf, 15'h7fff, 1, zero_bits[6-i], 1, 0));
        tbl.push_back(mk(0, 0, 2'b00, 4'd0, 15'h0, 1, 0, 0, 1));
        tbl.push_back(mk(0, 0, 2'b00, 4'd0, 15'h0, 1, 0, 0, 0));

        foreach (tbl[k]) begin
            step(tbl[k].r, tbl[k].s, tbl[k].p, tbl[k].l, tbl[k].d, tbl[k].b, 0);
            cmp("tbl_ser", ser_out, tbl[k].e_ser);
            cmp("tbl_busy", busy, tbl[k].e_busy);
            cmp("tbl_done", done, tbl[k].e_done);
        end

        // Stall: bit_en every third cycle, eleven bits held three cycles each.
        run_frame(2'b10, 4'd4, 15'b1011, 3, bc);
        nvec++;
        if (bc != 33) begin
            nmis++;
            $display("FAIL stall_len: busy %0d cycles expected 33", bc);
        end
        step(0, 0, 0, 0, 0, 1, 1);

        // Max length with a mid-frame start, then start in the done cycle.
        step(0, 1, 2'b11, 4'd15, 15'h5555, 1, 1);
        bc = 1;
        for (int i = 0; i < 40 && !m_done; i++) begin
            step(0, (i == 4), 2'b00, 4'd2, 15'h0, 1, 1);
            if (busy) bc++;
        end
        nvec++;
        if (bc != 22) begin
            nmis++;
            $display("FAIL maxlen_len: busy %0d cycles expected 22", bc);
        end
        cmp("done_cycle_ser", ser_out, 1'b0);
        run_frame(2'b01, 4'd3, 15'b110, 1, bc);
        nvec++;
        if (bc != 10) begin
            nmis++;
            $display("FAIL b2b_len: busy %0d cycles expected 10", bc);
        end

        // Reset in the DATA state, then a clean frame.
        step(0, 1, 2'b10, 4'd8, 15'hA5, 1, 1);
        for (int i = 0; i < 9; i++) step(0, 0, 0, 0, 0, 1, 1);
        step(1, 0, 0, 0, 0, 1, 1);
        cmp("rst_busy", busy, 1'b0);
        for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 0, 1, 1);
        run_frame(2'b11, 4'd5, 15'h15, 2, bc);

        // Random traffic against the model.
        for (int i = 0; i < 600; i++) begin
            step(($urandom % 113) == 0, ($urandom % 4) == 0,
                 2'($urandom), 4'($urandom), DW'($urandom),
                 ($urandom % 3) != 0, 1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
